// File: rtl/zap_cp_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : zap_cp_issue_if
// Description : Coprocessor issue handshake. The issuing side drives the
//               coprocessor word and its valid flag; the coprocessor answers
//               with a single-cycle completion pulse.
//               Signals:
//                 o_cp_word [31:0] - coprocessor instruction word (issuer out)
//                 o_cp_dav         - o_cp_word is valid (issuer out)
//                 i_cp_done        - coprocessor completion pulse (issuer in)
// Revision    : 1.0 - initial release
// ============================================================================
interface zap_cp_issue_if;
    logic [31:0] o_cp_word;
    logic        o_cp_dav;
    logic        i_cp_done;

    // Issuer (zap_cp_issue) side.
    modport master (
        output o_cp_word,
        output o_cp_dav,
        input  i_cp_done
    );

    // Coprocessor side.
    modport slave (
        input  o_cp_word,
        input  o_cp_dav,
        output i_cp_done
    );
endinterface
`default_nettype wire

// File: rtl/zap_cp_issue.sv
`default_nettype none
// ============================================================================
// Module      : zap_cp_issue
// Description : Coprocessor instruction issue stage. Ordinary instructions
//               pass through with one cycle of latency. MCR/MRC to p15 is
//               handed to the coprocessor over the cp handshake and held
//               until completion or timeout. Any other coprocessor
//               instruction (other coprocessor number, CDP, LDC, STC) raises
//               a one-cycle undefined trap.
//               Ports:
//                 i_clk, i_reset            - clock, synchronous active-high reset
//                 i_instruction[31:0]       - instruction from decode
//                 i_instruction_valid       - i_instruction is valid
//                 i_flush                   - pipeline flush (highest priority)
//                 i_stall                   - downstream stall
//                 o_stall_from_cp           - combinational stall back to decode
//                 o_instruction[31:0]       - registered pass-through instruction
//                 o_instruction_valid       - registered pass-through valid
//                 o_und                     - registered undefined-trap pulse
//                 cp (zap_cp_issue_if.master) - coprocessor word/dav/done
// Revision    : 1.0 - initial release
// ============================================================================
module zap_cp_issue #(
    parameter int CP_TIMEOUT = 16
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    input  wire logic [31:0] i_instruction,
    input  wire logic        i_instruction_valid,
    input  wire logic        i_flush,
    input  wire logic        i_stall,
    output logic             o_stall_from_cp,
    output logic [31:0]      o_instruction,
    output logic             o_instruction_valid,
    output logic             o_und,
    zap_cp_issue_if.master   cp
);

    // One bit wider than strictly needed so CP_TIMEOUT-1 always fits and the
    // saturation guard has headroom.
    localparam int                CNT_W        = $clog2(CP_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(CP_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        word_q, word_d;
    logic               dav_q, dav_d;
    logic [31:0]        instr_q, instr_d;
    logic               ivalid_q, ivalid_d;
    logic               und_q, und_d;

    // Instruction classification.
    logic w_is_reg_xfer;   // MCR/MRC
    logic w_is_undef_cp;   // CDP, LDC, STC
    logic w_is_p15;
    logic w_is_issue;      // valid MCR/MRC to p15

    always_comb begin
        w_is_reg_xfer = (i_instruction[27:24] == 4'hE) && i_instruction[4];
        w_is_undef_cp = ((i_instruction[27:24] == 4'hE) && !i_instruction[4]) ||
                        (i_instruction[27:25] == 3'b110);
        w_is_p15      = (i_instruction[11:8] == 4'hF);
        w_is_issue    = i_instruction_valid && w_is_reg_xfer && w_is_p15;
    end

    // Decode is held off while busy, and also in the very cycle a p15
    // transfer is being accepted so it does not advance past it.
    always_comb begin
        o_stall_from_cp = (state_q != IDLE) || w_is_issue;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        dav_d    = dav_q;
        instr_d  = instr_q;
        ivalid_d = ivalid_q;
        und_d    = und_q;

        case (state_q)
            IDLE: begin
                // With i_stall high every registered output simply holds.
                if (!i_stall) begin
                    instr_d  = i_instruction;
                    ivalid_d = 1'b0;
                    und_d    = 1'b0;
                    dav_d    = 1'b0;
                    if (i_instruction_valid) begin
                        if (w_is_reg_xfer && w_is_p15) begin
                            word_d  = i_instruction;
                            dav_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = ISSUE;
                        end else if (w_is_reg_xfer || w_is_undef_cp) begin
                            und_d = 1'b1;
                        end else begin
                            ivalid_d = 1'b1;
                        end
                    end
                end
            end

            ISSUE: begin
                ivalid_d = 1'b0;
                und_d    = 1'b0;
                // Completion outranks a coincident timeout.
                if (cp.i_cp_done) begin
                    dav_d   = 1'b0;
                    state_d = RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    dav_d   = 1'b0;
                    und_d   = 1'b1;
                    state_d = RELEASE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                // One dead cycle with dav low so the coprocessor can leave
                // its terminal state without seeing a stale dav.
                dav_d    = 1'b0;
                ivalid_d = 1'b0;
                und_d    = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                dav_d    = 1'b0;
                ivalid_d = 1'b0;
                und_d    = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase

        // Flush overrides everything, including a same-cycle completion.
        if (i_flush) begin
            state_d  = IDLE;
            dav_d    = 1'b0;
            ivalid_d = 1'b0;
            und_d    = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            dav_q    <= 1'b0;
            instr_q  <= '0;
            ivalid_q <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            dav_q    <= dav_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            und_q    <= und_d;
        end
    end

    assign cp.o_cp_word        = word_q;
    assign cp.o_cp_dav         = dav_q;
    assign o_instruction       = instr_q;
    assign o_instruction_valid = ivalid_q;
    assign o_und               = und_q;

endmodule
`default_nettype wire

// File: tb/tb_zap_cp_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_zap_cp_issue
// Description : Directed self-checking bench for zap_cp_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zap_cp_issue;

    logic        clk;
    logic        rst;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_flush;
    logic        r_stall;
    logic        w_stall_from_cp;
    logic [31:0] w_instr_o;
    logic        w_valid_o;
    logic        w_und;

    int checks;
    int errors;

    zap_cp_issue_if cp_if ();

    zap_cp_issue #(.CP_TIMEOUT(16)) dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_instruction       (r_instr),
        .i_instruction_valid (r_valid),
        .i_flush             (r_flush),
        .i_stall             (r_stall),
        .o_stall_from_cp     (w_stall_from_cp),
        .o_instruction       (w_instr_o),
        .o_instruction_valid (w_valid_o),
        .o_und               (w_und),
        .cp                  (cp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        r_instr = 32'h0;
        r_valid = 1'b0;
        r_flush = 1'b0;
        r_stall = 1'b0;
        cp_if.i_cp_done = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_dav",    {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("rst_word",   cp_if.o_cp_word, 32'd0);
        chk("rst_instr",  w_instr_o, 32'd0);
        chk("rst_valid",  {31'd0, w_valid_o}, 32'd0);
        chk("rst_und",    {31'd0, w_und}, 32'd0);
        chk("rst_stall",  {31'd0, w_stall_from_cp}, 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- pass-through ----------------
        r_instr = 32'hE1A00000;
        r_valid = 1'b1;
        #1;
        chk("pt_stall_comb", {31'd0, w_stall_from_cp}, 32'd0);
        tick();
        chk("pt_instr", w_instr_o, 32'hE1A00000);
        chk("pt_valid", {31'd0, w_valid_o}, 32'd1);
        chk("pt_dav",   {31'd0, cp_if.o_cp_dav}, 32'd0);
        r_valid = 1'b0;
        tick();
        chk("pt_valid_drop", {31'd0, w_valid_o}, 32'd0);

        // ---------------- stall holds outputs ----------------
        r_instr = 32'hE3A01001;
        r_valid = 1'b1;
        tick();
        chk("st_instr0", w_instr_o, 32'hE3A01001);
        r_stall = 1'b1;
        r_instr = 32'hE1A00000;
        tick();
        chk("st_instr_hold", w_instr_o, 32'hE3A01001);
        chk("st_valid_hold", {31'd0, w_valid_o}, 32'd1);
        r_stall = 1'b0;
        r_valid = 1'b0;
        tick();
        chk("st_valid_drop", {31'd0, w_valid_o}, 32'd0);

        // ---------------- MCR to p15, done in 4th dav cycle ----------------
        r_instr = 32'hEE010F10;
        r_valid = 1'b1;
        #1;
        chk("mcr_stall_comb", {31'd0, w_stall_from_cp}, 32'd1);
        tick();
        r_valid = 1'b0;
        r_instr = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            chk("mcr_dav_hi", {31'd0, cp_if.o_cp_dav}, 32'd1);
            chk("mcr_word",   cp_if.o_cp_word, 32'hEE010F10);
            chk("mcr_stall",  {31'd0, w_stall_from_cp}, 32'd1);
            chk("mcr_ivalid", {31'd0, w_valid_o}, 32'd0);
            if (k == 4) cp_if.i_cp_done = 1'b1;
            tick();
        end
        // RELEASE (done left high: must be ignored here)
        chk("mcr_rel_dav",   {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("mcr_rel_stall", {31'd0, w_stall_from_cp}, 32'd1);
        chk("mcr_rel_und",   {31'd0, w_und}, 32'd0);
        chk("mcr_rel_word",  cp_if.o_cp_word, 32'hEE010F10);
        tick();
        chk("mcr_idle_dav",   {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("mcr_idle_stall", {31'd0, w_stall_from_cp}, 32'd0);
        tick();
        chk("mcr_idle_done_ign", {31'd0, cp_if.o_cp_dav}, 32'd0);
        cp_if.i_cp_done = 1'b0;

        // ---------------- wrong coprocessor (p14) ----------------
        r_instr = 32'hEE010E10;
        r_valid = 1'b1;
        #1;
        chk("p14_stall_comb", {31'd0, w_stall_from_cp}, 32'd0);
        tick();
        chk("p14_und",    {31'd0, w_und}, 32'd1);
        chk("p14_dav",    {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("p14_ivalid", {31'd0, w_valid_o}, 32'd0);
        r_valid = 1'b0;
        tick();
        chk("p14_und_drop", {31'd0, w_und}, 32'd0);
        chk("p14_dav2",     {31'd0, cp_if.o_cp_dav}, 32'd0);

        // ---------------- LDC is undefined ----------------
        r_instr = 32'hED900100;
        r_valid = 1'b1;
        tick();
        chk("ldc_und", {31'd0, w_und}, 32'd1);
        chk("ldc_dav", {31'd0, cp_if.o_cp_dav}, 32'd0);
        r_valid = 1'b0;
        tick();

        // ---------------- timeout ----------------
        r_instr = 32'hEE110F10;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            chk("to_dav_hi", {31'd0, cp_if.o_cp_dav}, 32'd1);
            chk("to_und_lo", {31'd0, w_und}, 32'd0);
            tick();
        end
        chk("to_dav_drop", {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("to_und",      {31'd0, w_und}, 32'd1);
        chk("to_rel_stall",{31'd0, w_stall_from_cp}, 32'd1);
        tick();
        chk("to_und_once", {31'd0, w_und}, 32'd0);
        chk("to_idle",     {31'd0, w_stall_from_cp}, 32'd0);

        // ---------------- done and timeout coincide ----------------
        r_instr = 32'hEE110F10;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        for (int k = 1; k <= 15; k++) tick();
        chk("dt_dav_last", {31'd0, cp_if.o_cp_dav}, 32'd1);
        cp_if.i_cp_done = 1'b1;
        tick();
        cp_if.i_cp_done = 1'b0;
        chk("dt_dav", {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("dt_und", {31'd0, w_und}, 32'd0);
        tick();

        // ---------------- flush versus done ----------------
        r_instr = 32'hEE010F10;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        tick();
        r_flush = 1'b1;
        cp_if.i_cp_done = 1'b1;
        tick();
        r_flush = 1'b0;
        cp_if.i_cp_done = 1'b0;
        chk("fl_dav",   {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("fl_und",   {31'd0, w_und}, 32'd0);
        chk("fl_stall", {31'd0, w_stall_from_cp}, 32'd0);

        // flush in IDLE kills a pass-through
        r_instr = 32'hE1A00000;
        r_valid = 1'b1;
        r_flush = 1'b1;
        tick();
        r_flush = 1'b0;
        r_valid = 1'b0;
        chk("fl_pt_valid", {31'd0, w_valid_o}, 32'd0);

        // ---------------- reset mid-ISSUE ----------------
        r_instr = 32'hEE010F10;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        tick();
        chk("rs_dav_pre", {31'd0, cp_if.o_cp_dav}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_dav",   {31'd0, cp_if.o_cp_dav}, 32'd0);
        chk("rs_word",  cp_if.o_cp_word, 32'd0);
        chk("rs_instr", w_instr_o, 32'd0);
        chk("rs_valid", {31'd0, w_valid_o}, 32'd0);
        chk("rs_und",   {31'd0, w_und}, 32'd0);
        chk("rs_stall", {31'd0, w_stall_from_cp}, 32'd0);
        r_instr = 32'hE1A00000;
        r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        chk("rs_pt_instr", w_instr_o, 32'hE1A00000);
        chk("rs_pt_valid", {31'd0, w_valid_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zap_cp_issue.md
ZAP_CP_ISSUE -- requirements
Module: zap_cp_issue

Interface
REQ-001 SHALL have parameter CP_TIMEOUT, default 16: the maximum number of cycles o_cp_dav is held before the instruction is declared undefined.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port i_instruction, input, 32 bits: the instruction from decode.
REQ-005 SHALL have port i_instruction_valid, input, 1 bit: i_instruction is valid.
REQ-006 SHALL have port i_flush, input, 1 bit: pipeline flush.
REQ-007 SHALL have port i_stall, input, 1 bit: downstream stall.
REQ-008 SHALL have port o_stall_from_cp, output, 1 bit: combinational stall to decode while this block is busy.
REQ-009 SHALL have port o_cp_word, output, 32 bits, registered: the coprocessor instruction word.
REQ-010 SHALL have port o_cp_dav, output, 1 bit, registered: the coprocessor word is valid.
REQ-011 SHALL have port i_cp_done, input, 1 bit: coprocessor completion pulse.
REQ-012 SHALL have port o_instruction, output, 32 bits, registered: the pass-through instruction.
REQ-013 SHALL have port o_instruction_valid, output, 1 bit, registered: the pass-through valid.
REQ-014 SHALL have port o_und, output, 1 bit, registered: one-cycle undefined-instruction trap pulse.

Function
REQ-015 SHALL classify an instruction as MCR/MRC when i_instruction[27:24]==4'hE and i_instruction[4]==1; CDP, LDC and STC ([27:24]==4'hE with [4]==0, or [27:25]==3'b110) SHALL be classified as undefined.
REQ-016 SHALL implement states IDLE, ISSUE and RELEASE.
REQ-017 In IDLE with !i_stall, a valid non-coprocessor instruction SHALL appear on o_instruction/o_instruction_valid the next cycle (1-cycle latency).
REQ-018 In IDLE with !i_stall, a valid MCR/MRC with [11:8]==15 SHALL latch o_cp_word, set o_cp_dav=1 and o_instruction_valid=0, clear the timeout counter, and go to ISSUE.
REQ-019 In IDLE with !i_stall, a valid MCR/MRC with [11:8]!=15, or a valid CDP/LDC/STC, SHALL pulse o_und for 1 cycle, set o_instruction_valid=0, and not assert o_cp_dav.
REQ-020 In IDLE with i_stall=1, all registered outputs SHALL hold and no instruction SHALL be accepted.
REQ-021 In ISSUE, o_cp_word SHALL remain stable, o_cp_dav SHALL remain 1, and the counter SHALL increment by 1 per cycle.
REQ-022 In ISSUE, when i_cp_done=1, the block SHALL deassert o_cp_dav on the next edge and go to RELEASE.
REQ-023 In ISSUE, when the counter reaches CP_TIMEOUT-1 without i_cp_done, the block SHALL deassert o_cp_dav, pulse o_und, and go to RELEASE.
REQ-024 When i_cp_done and the timeout occur in the same cycle, done SHALL win and o_und SHALL NOT pulse.
REQ-025 RELEASE SHALL last exactly 1 cycle with o_cp_dav=0, then go to IDLE; this gap lets a coprocessor in TERM return to IDLE without resampling o_cp_dav.
REQ-026 o_stall_from_cp SHALL equal (state!=IDLE) OR (state==IDLE AND i_instruction_valid AND the instruction is MCR/MRC to p15).
REQ-027 i_cp_done SHALL be ignored in IDLE and RELEASE.
REQ-028 i_flush SHALL have priority over all other events in every state: next cycle state=IDLE, o_cp_dav=0, o_instruction_valid=0, o_und=0, counter=0, and a same-cycle i_cp_done SHALL be discarded.
REQ-029 The counter SHALL be $clog2(CP_TIMEOUT)+1 bits wide and SHALL saturate, never wrapping.

Reset
REQ-030 While i_reset=1 the block SHALL set state=IDLE, counter=0, o_cp_dav=0, o_cp_word=0, o_instruction=0, o_instruction_valid=0 and o_und=0; reset mid-ISSUE SHALL drop o_cp_dav on the next edge.

Verification
REQ-031 SHALL verify pass-through: i_instruction=0xE1A00000 valid -> o_instruction=0xE1A00000, o_instruction_valid=1 one cycle later, o_stall_from_cp=0.
REQ-032 SHALL verify MCR issue: 0xEE010F10 valid, i_cp_done returned 4 cycles after o_cp_dav rises -> o_cp_dav high for exactly 4 cycles, then 1 RELEASE cycle, then IDLE; o_cp_word=0xEE010F10 throughout; o_stall_from_cp high until the return to IDLE.
REQ-033 SHALL verify the wrong coprocessor: 0xEE010E10 (p14) -> o_und high for 1 cycle, o_cp_dav never asserted.
REQ-034 SHALL verify timeout: 0xEE110F10 with i_cp_done tied low -> o_cp_dav high for 16 cycles, then o_und pulses once, then return to IDLE.
REQ-035 SHALL verify flush versus done: i_flush and i_cp_done asserted together in ISSUE -> next cycle IDLE, o_cp_dav=0, o_und=0.
REQ-036 SHALL verify reset mid-ISSUE: i_reset asserted in the 2nd ISSUE cycle -> all outputs 0 next cycle; a following 0xE1A00000 passes through normally.
